// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB / counter / return-stack branch predictor.
// Entry storage widths come from the package so the packed entry type has a fixed layout.
package branch_predictor_pkg;

  localparam int unsigned BP_PC_W  = 32;
  localparam int unsigned BP_TAG_W = 10;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    br_type_t            br_type;
    logic [BP_PC_W-1:0]  target;
    logic [1:0]          ctr;
  } btb_entry_t;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Two-bit saturating counter step; 00 and 11 hold at their ends.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor_return_stack.sv
// Circular return-address stack: push overwrites the oldest entry once full, pop on empty is ignored.
module return_stack
  #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 3
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_c,
    output logic             empty_c
  );

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] top_ptr;
  logic [DEPTH_LOG2-1:0] push_ptr;
  logic [DEPTH_LOG2:0]   count;

  assign push_ptr = top_ptr + DEPTH_LOG2'(1);
  assign top_c    = mem[top_ptr];
  assign empty_c  = (count == '0);

  // Pointer and occupancy; push takes priority, callers never assert both.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= push_ptr;
      if (count != (DEPTH_LOG2 + 1)'(DEPTH)) begin
        count <= count + (DEPTH_LOG2 + 1)'(1);
      end
    end else if (pop && !empty_c) begin
      top_ptr <= top_ptr - DEPTH_LOG2'(1);
      count   <= count - (DEPTH_LOG2 + 1)'(1);
    end
  end

  // Storage needs no reset; count gates every read that matters.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[push_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged direct-mapped BTB with 2-bit counters plus a return-address stack.
// IF looks up combinationally; EX trains on the next clock edge unless stalled.
module branch_predictor
  import branch_predictor_pkg::*;
  #(
    parameter int unsigned WIDTH     = BP_PC_W,
    parameter int unsigned BTB_SIZE  = 6,
    parameter int unsigned TAG_W     = BP_TAG_W,
    parameter int unsigned RAS_DEPTH = 3
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_pc,
    input  br_type_t         up_type,
    input  logic             up_taken,
    input  logic [WIDTH-1:0] up_target,
    input  logic             up_mispredict,
    input  logic             stall,
    output logic [31:0]      mispredict_cnt
  );

  localparam int unsigned ENTRIES = 1 << BTB_SIZE;

  btb_entry_t btb [ENTRIES];

  logic [BTB_SIZE-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic [BTB_SIZE-1:0] up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic                up_hit;
  logic                up_en;
  logic                up_we;
  btb_entry_t          up_old;
  btb_entry_t          up_new;
  logic                ras_push;
  logic                ras_pop;
  logic [WIDTH-1:0]    ras_top_c;
  logic                ras_empty_c;
  logic [WIDTH-1:0]    ret_addr;

  assign lk_idx   = if_pc[BTB_SIZE+1:2];
  assign lk_tag   = if_pc[TAG_W+BTB_SIZE+1:BTB_SIZE+2];
  assign up_idx   = up_pc[BTB_SIZE+1:2];
  assign up_tag   = up_pc[TAG_W+BTB_SIZE+1:BTB_SIZE+2];
  assign up_en    = up_valid && !stall;
  assign ras_push = up_en && (up_type == BR_CALL);
  assign ras_pop  = up_en && (up_type == BR_RET);
  assign ret_addr = up_pc + WIDTH'(4);

  // Lookup path: reads the array before any same-cycle write lands.
  always_comb begin
    lk_hit      = btb[lk_idx].valid && (btb[lk_idx].tag == BP_TAG_W'(lk_tag));
    pred_taken  = 1'b0;
    pred_target = if_pc + WIDTH'(4);
    if (lk_hit) begin
      unique case (btb[lk_idx].br_type)
        BR_COND: begin
          if (btb[lk_idx].ctr[1]) begin
            pred_taken  = 1'b1;
            pred_target = WIDTH'(btb[lk_idx].target);
          end
        end
        BR_JUMP, BR_CALL: begin
          pred_taken  = 1'b1;
          pred_target = WIDTH'(btb[lk_idx].target);
        end
        BR_RET: begin
          if (!ras_empty_c) begin
            pred_taken  = 1'b1;
            pred_target = ras_top_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Training: build the replacement entry for the EX-stage instruction.
  always_comb begin
    up_old = btb[up_idx];
    up_hit = up_old.valid && (up_old.tag == BP_TAG_W'(up_tag));
    up_we  = 1'b0;
    up_new = up_old;
    if (up_en) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (up_type == BR_COND) begin
          up_new.ctr = ctr_next(up_old.ctr, up_taken);
        end
        if (up_taken) begin
          up_new.target  = BP_PC_W'(up_target);
          up_new.br_type = up_type;
        end
      end else if (up_taken) begin
        up_we          = 1'b1;
        up_new.valid   = 1'b1;
        up_new.tag     = BP_TAG_W'(up_tag);
        up_new.br_type = up_type;
        up_new.target  = BP_PC_W'(up_target);
        up_new.ctr     = CTR_ALLOC;
      end
    end
  end

  // Reset clears only valid and counter; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= CTR_RESET;
      end
    end else if (up_we) begin
      btb[up_idx] <= up_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (up_en && up_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  return_stack #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ret_addr),
    .top_c     (ras_top_c),
    .empty_c   (ras_empty_c)
  );

endmodule
